// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - frame-rate Pong controller: paddles, ball, bounces, score, serve/play/over
// Optional BALL_SPEEDUP_EN: ball speed steps up by one per paddle hit, saturating at 6.
module pong_game_ctrl #(
   parameter int BALL_SPEED   = 2,
   parameter int PADDLE_SPEED = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9
) (
   input  logic       VGA_CLOCK,
   input  logic       RESET,
   input  logic       FRAME_TICK,
   input  logic       START,
   input  logic       P1_UP,
   input  logic       P1_DOWN,
   input  logic       P2_UP,
   input  logic       P2_DOWN,
   output logic [9:0] PADDLE1Y,
   output logic [9:0] PADDLE2Y,
   output logic [9:0] BALLX,
   output logic [9:0] BALLY,
   output logic [3:0] SCORE1,
   output logic [3:0] SCORE2,
   output logic       GAME_OVER
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SERVE = 2'd1;
   localparam logic [1:0] PLAY  = 2'd2;
   localparam logic [1:0] OVER  = 2'd3;

   localparam logic [9:0]         CX         = 10'd320;
   localparam logic [9:0]         CY         = 10'd240;
   localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
   localparam logic [15:0]        SERVE_LAST = 16'(SERVE_FRAMES);
   localparam logic signed [10:0] PSTEP      = 11'(PADDLE_SPEED);

   logic [1:0]         state, state_n;
   logic [15:0]        cnt, cnt_n;
   logic               dx, dx_n, dy, dy_n, wall_dy;
   logic [9:0]         p1_n, p2_n, bx_n, by_n;
   logic [3:0]         s1_n, s2_n;
   logic signed [10:0] step, nx, ny, d1, d2;
   logic               hit1, hit2;

`ifdef BALL_SPEEDUP_EN
   logic [2:0] speed;

   always_ff @(posedge VGA_CLOCK or posedge RESET) begin
      if (RESET)
         speed <= 3'(BALL_SPEED);
      else if (state_n == SERVE && state != SERVE)
         speed <= 3'(BALL_SPEED);
      else if (state == PLAY && FRAME_TICK && (hit1 || hit2) && speed != 3'd6)
         speed <= speed + 3'd1;
   end
`else
   localparam logic [2:0] speed = 3'(BALL_SPEED);
`endif

   assign step = $signed({8'd0, speed});

   function automatic logic [9:0] paddle_move(input logic [9:0] y, input logic up, input logic down);
      logic signed [10:0] p;
      p = $signed({1'b0, y});
      if (up && !down)
         p = p - PSTEP;
      else if (down && !up)
         p = p + PSTEP;
      if (p < 11'sd26)
         p = 11'sd26;
      else if (p > 11'sd453)
         p = 11'sd453;
      return p[9:0];
   endfunction

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dx_n    = dx;
      dy_n    = dy;
      p1_n    = PADDLE1Y;
      p2_n    = PADDLE2Y;
      bx_n    = BALLX;
      by_n    = BALLY;
      s1_n    = SCORE1;
      s2_n    = SCORE2;

      nx      = $signed({1'b0, BALLX}) + (dx ? step : -step);
      ny      = $signed({1'b0, BALLY}) + (dy ? step : -step);
      wall_dy = dy;
      if (ny <= 11'sd6) begin
         ny      = 11'sd6;
         wall_dy = 1'b1;
      end else if (ny >= 11'sd473) begin
         ny      = 11'sd473;
         wall_dy = 1'b0;
      end
      // Hit window uses the post-bounce Y and the paddles as registered before this tick.
      d1   = ny - $signed({1'b0, PADDLE1Y});
      d2   = ny - $signed({1'b0, PADDLE2Y});
      hit1 = !dx && (nx <= 11'sd30)  && (d1 > -11'sd30) && (d1 < 11'sd30);
      hit2 =  dx && (nx >= 11'sd610) && (d2 > -11'sd30) && (d2 < 11'sd30);

      case (state)
         IDLE: begin
            if (START) begin
               state_n = SERVE;
               cnt_n   = '0;
            end
         end
         SERVE: begin
            if (FRAME_TICK) begin
               p1_n = paddle_move(PADDLE1Y, P1_UP, P1_DOWN);
               p2_n = paddle_move(PADDLE2Y, P2_UP, P2_DOWN);
               bx_n = CX;
               by_n = CY;
               if (cnt + 16'd1 == SERVE_LAST) begin
                  state_n = PLAY;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 16'd1;
               end
            end
         end
         PLAY: begin
            if (FRAME_TICK) begin
               p1_n = paddle_move(PADDLE1Y, P1_UP, P1_DOWN);
               p2_n = paddle_move(PADDLE2Y, P2_UP, P2_DOWN);
               dy_n = wall_dy;
               by_n = ny[9:0];
               if (hit1) begin
                  bx_n = 10'd30;
                  dx_n = 1'b1;
               end else if (hit2) begin
                  bx_n = 10'd610;
                  dx_n = 1'b0;
               end else if (!dx && nx <= 11'sd5) begin
                  s2_n    = (SCORE2 == WIN) ? WIN : SCORE2 + 4'd1;
                  bx_n    = CX;
                  by_n    = CY;
                  dx_n    = 1'b0;
                  state_n = (s2_n == WIN) ? OVER : SERVE;
                  cnt_n   = '0;
               end else if (dx && nx >= 11'sd634) begin
                  s1_n    = (SCORE1 == WIN) ? WIN : SCORE1 + 4'd1;
                  bx_n    = CX;
                  by_n    = CY;
                  dx_n    = 1'b1;
                  state_n = (s1_n == WIN) ? OVER : SERVE;
                  cnt_n   = '0;
               end else begin
                  bx_n = nx[9:0];
               end
            end
         end
         default: begin
            if (START) begin
               s1_n    = '0;
               s2_n    = '0;
               p1_n    = CY;
               p2_n    = CY;
               bx_n    = CX;
               by_n    = CY;
               state_n = SERVE;
               cnt_n   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge VGA_CLOCK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         cnt       <= '0;
         dx        <= 1'b1;
         dy        <= 1'b1;
         PADDLE1Y  <= CY;
         PADDLE2Y  <= CY;
         BALLX     <= CX;
         BALLY     <= CY;
         SCORE1    <= '0;
         SCORE2    <= '0;
         GAME_OVER <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         dx        <= dx_n;
         dy        <= dy_n;
         PADDLE1Y  <= p1_n;
         PADDLE2Y  <= p2_n;
         BALLX     <= bx_n;
         BALLY     <= by_n;
         SCORE1    <= s1_n;
         SCORE2    <= s2_n;
         GAME_OVER <= (state_n == OVER);
      end
   end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Frame-rate game controller for the VGA Pong datapath.
- Once per frame, updates paddle and ball positions from player buttons, resolves wall/paddle bounces, keeps score and sequences serve/play/game-over.
- Drives the PADDLE1Y/PADDLE2Y/BALLX/BALLY inputs of the pixel renderer.
- Field: 640x480. Paddle centres at X=20 and X=620, half-size 5x25. Ball half-size 5. Border at 0/639 and 0/479.

Parameters:
BALL_SPEED, 2, ball pixels per frame on each axis
PADDLE_SPEED, 4, paddle pixels per frame
SERVE_FRAMES, 60, frames the ball is held at centre before play
WIN_SCORE, 9, score that ends the game (1..15)

Ports:
VGA_CLOCK  input  1  pixel clock; all state on rising edge
RESET  input  1  asynchronous, active-high reset
FRAME_TICK  input  1  one-cycle pulse per frame (start of vertical blank)
START  input  1  level; begins or restarts a game
P1_UP, P1_DOWN, P2_UP, P2_DOWN  input  1 each  player buttons, already synchronised
PADDLE1Y, PADDLE2Y  output  10  paddle centre Y
BALLX, BALLY  output  10  ball centre
SCORE1, SCORE2  output  4  player scores
GAME_OVER  output  1  high in OVER state

Behaviour:
- Reset values: state IDLE; PADDLE1Y=PADDLE2Y=240; BALLX=320; BALLY=240; scores 0; GAME_OVER=0; direction dx=+ (right), dy=+ (down); serve counter 0.
- All outputs are registered and update on the edge after the sampled event (latency 1).
- Positions change only on edges with FRAME_TICK=1.
- States:
  - IDLE: everything held. START=1 (FRAME_TICK not required) -> SERVE with counter cleared. A coincident FRAME_TICK is not counted.
  - SERVE: ball held at (320,240). Counter increments per FRAME_TICK. Reaching SERVE_FRAMES -> PLAY, counter cleared.
  - PLAY: ball and paddles move per FRAME_TICK.
  - OVER: GAME_OVER=1, everything held. START -> clear scores, centre paddles and ball, enter SERVE.
- Paddles, in SERVE and PLAY only:
  - UP alone: Y-=PADDLE_SPEED. DOWN alone: Y+=PADDLE_SPEED. Both or neither: no move.
  - Result clamped to [26,453].
  - Compute in 11-bit signed so no underflow occurs.
- Ball, in PLAY, per tick:
  - nx=X±speed, ny=Y±speed per dx/dy, computed in 11-bit signed.
  - Y wall: ny<=6 -> Y=6, dy=+. ny>=473 -> Y=473, dy=-.
  - Left side (dx=-):
    - nx<=30 and |ny-PADDLE1Y|<30 -> X=30, dx=+ (hit).
    - Else nx<=5 -> SCORE2+1, point.
  - Right side (dx=+):
    - nx>=610 and |ny-PADDLE2Y|<30 -> X=610, dx=- (hit).
    - Else nx>=634 -> SCORE1+1, point.
  - Paddle comparisons use the paddle values registered before this tick, not the same-tick updated ones.
- Point:
  - Ball returns to (320,240). dx points toward the player who conceded; dy unchanged.
  - If the new score equals WIN_SCORE -> OVER, else -> SERVE with counter cleared.
  - Scores never exceed WIN_SCORE and never wrap.
- Ordering: a wall bounce and a paddle hit in the same tick are both applied. Score detection uses the post-bounce Y.
- RESET asserted mid-game forces all reset values immediately, independent of clock.

Optional Feature:
- Macro BALL_SPEEDUP_EN.
- Defined:
  - Internal 3-bit speed register, starts at BALL_SPEED.
  - Each paddle hit increments it by 1, saturating at 6.
  - Reloaded to BALL_SPEED on every entry to SERVE.
  - Wall/paddle/score thresholds unchanged.
- Undefined: ball speed is constantly BALL_SPEED; no speed register exists.

Test Plan:
- Reset then release: outputs 240/240/320/240, scores 0, GAME_OVER=0. START, then 60 FRAME_TICKs -> still (320,240), state PLAY. Next tick -> BALLX=322, BALLY=242.
- P1_UP held for 100 ticks in SERVE -> PADDLE1Y stops at 26. P1_UP+P1_DOWN together -> no change.
- PLAY, PADDLE1Y=26, dx=-, BALLY=240, ticks until nx<=5 -> SCORE2=1, ball at (320,240), dx=-, SERVE entered.
- PADDLE2Y=240, ball approaching at Y=250: X reaches 610 and dx flips to -. Separately, ny<=6 -> BALLY=6, dy=+.
- Force SCORE1 to WIN_SCORE via repeated misses by P2 -> GAME_OVER=1 and all outputs frozen. START -> scores 0, SERVE.
- RESET pulsed mid-PLAY between clock edges -> outputs return to reset values without waiting for a clock edge.
